// File: rtl/run_ctrl_if.sv
// Host/core side bundle of the run controller: run commands, core status and run results.
interface run_ctrl_if #(
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned NUM_BP = 2
);
   logic                     start;
   logic [1:0]               mode;
   logic [CNT_W-1:0]         run_len;
   logic                     step;
   logic                     abort;
   logic                     halt;
   logic                     icycle;
   logic [ADDR_W-1:0]        pc;
   logic [NUM_BP*ADDR_W-1:0] bp_addr;
   logic [NUM_BP-1:0]        bp_en;
   logic                     cpu_en;
   logic                     busy;
   logic                     done;
   logic [2:0]               stop_cause;
   logic [CNT_W-1:0]         cycle_cnt;
   logic [CNT_W-1:0]         instr_cnt;

   // controller side
   modport slave (
      input  start, mode, run_len, step, abort, halt, icycle, pc, bp_addr, bp_en,
      output cpu_en, busy, done, stop_cause, cycle_cnt, instr_cnt
   );

   // host/bench side
   modport master (
      output start, mode, run_len, step, abort, halt, icycle, pc, bp_addr, bp_en,
      input  cpu_en, busy, done, stop_cause, cycle_cnt, instr_cnt
   );
endinterface

// File: rtl/run_ctrl.sv
// Run controller: gates the core clock-enable for free run, single step,
// run-N-cycles and run-N-instructions, with PC breakpoints and a cycle watchdog.
module run_ctrl #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned NUM_BP     = 2,
   parameter int unsigned MAX_CYCLES = 10
) (
   input  logic       clk,
   input  logic       reset,
   run_ctrl_if.slave  bus
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RUN       = 3'd1;
   localparam logic [2:0] ST_STEP_WAIT = 3'd2;
   localparam logic [2:0] ST_STEP_EXEC = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   localparam logic [2:0] C_NONE  = 3'd0;
   localparam logic [2:0] C_ABORT = 3'd1;
   localparam logic [2:0] C_HALT  = 3'd2;
   localparam logic [2:0] C_BP    = 3'd3;
   localparam logic [2:0] C_COUNT = 3'd4;
   localparam logic [2:0] C_TOUT  = 3'd5;

   logic [2:0]       state, state_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic [CNT_W-1:0] len_q, len_nxt;
   logic [2:0]       cause_q, cause_nxt;
   logic             first_q, first_nxt;
   logic             cpu_en_q, busy_q, done_q;
   logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
   logic             clr_cnt;
   logic             bp_hit;
   logic [2:0]       stop_c;

   // Stop cause for the current enabled cycle, highest priority first
   always_comb begin
      bp_hit = 1'b0;
      stop_c = C_NONE;
      for (int unsigned i = 0; i < NUM_BP; i++) begin
         if (bus.bp_en[i] && (bus.pc == bus.bp_addr[i*ADDR_W +: ADDR_W])) bp_hit = 1'b1;
      end
      if (bus.abort)
         stop_c = C_ABORT;
      else if (bus.halt)
         stop_c = C_HALT;
      else if (state == ST_RUN && bus.icycle && bp_hit)
         stop_c = C_BP;
      else if (state == ST_RUN &&
               ((mode_q == 2'b10 && (cycle_cnt_q + CNT_W'(1)) == len_q) ||
                (mode_q == 2'b11 && bus.icycle && (instr_cnt_q + CNT_W'(1)) == len_q)))
         stop_c = C_COUNT;
      else if (MAX_CYCLES != 0 && (cycle_cnt_q + CNT_W'(1)) == CNT_W'(MAX_CYCLES))
         stop_c = C_TOUT;
   end

   // Next-state and latched run parameters
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      len_nxt   = len_q;
      cause_nxt = cause_q;
      first_nxt = first_q;
      clr_cnt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               clr_cnt   = 1'b1;
               cause_nxt = C_NONE;
               mode_nxt  = bus.mode;
               len_nxt   = bus.run_len;
               if (bus.mode == 2'b01) begin
                  state_nxt = ST_STEP_WAIT;
               end else if (bus.mode[1] && bus.run_len == '0) begin
                  state_nxt = ST_DONE;
                  cause_nxt = C_COUNT;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (stop_c != C_NONE) begin
               state_nxt = ST_DONE;
               cause_nxt = stop_c;
            end
         end
         ST_STEP_WAIT: begin
            if (bus.abort) begin
               state_nxt = ST_DONE;
               cause_nxt = C_ABORT;
            end else if (bus.step) begin
               state_nxt = ST_STEP_EXEC;
               first_nxt = 1'b1;
            end
         end
         ST_STEP_EXEC: begin
            first_nxt = 1'b0;
            if (stop_c != C_NONE) begin
               state_nxt = ST_DONE;
               cause_nxt = stop_c;
            end else if (!first_q && bus.icycle) begin
               state_nxt = ST_STEP_WAIT;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, registered outputs and saturating counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         mode_q      <= 2'b00;
         len_q       <= '0;
         cause_q     <= C_NONE;
         first_q     <= 1'b0;
         cpu_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         state    <= state_nxt;
         mode_q   <= mode_nxt;
         len_q    <= len_nxt;
         cause_q  <= cause_nxt;
         first_q  <= first_nxt;
         cpu_en_q <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP_EXEC);
         busy_q   <= (state_nxt != ST_IDLE);
         done_q   <= (state_nxt == ST_DONE);
         if (clr_cnt) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
         end else if (cpu_en_q) begin
            if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (bus.icycle && instr_cnt_q != '1) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.cpu_en     = cpu_en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.stop_cause = cause_q;
   assign bus.cycle_cnt  = cycle_cnt_q;
   assign bus.instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: per-enabled-cycle core stimulus tables, a run-level
// reference model feeding a scoreboard, and a done-driven monitor.
module tb_run_ctrl;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned NUM_BP = 2;
   localparam int unsigned MAXC   = 10;
   localparam int          NV     = 64;

   typedef struct packed {
      logic        abort;
      logic        halt;
      logic        icycle;
      logic [15:0] pc;
   } cyc_t;

   typedef struct {
      logic [2:0] cause;
      int         cyc;
      int         ins;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   run_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .NUM_BP(NUM_BP)) bus ();

   run_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   logic                     start_h, step_h, abort_h;
   logic [1:0]               mode_h;
   logic [CNT_W-1:0]         len_h;
   logic [NUM_BP*ADDR_W-1:0] bpa_h;
   logic [NUM_BP-1:0]        bpe_h;
   logic                     abort_c, halt_c, icycle_c;
   logic [ADDR_W-1:0]        pc_c;

   assign bus.start   = start_h;
   assign bus.mode    = mode_h;
   assign bus.run_len = len_h;
   assign bus.step    = step_h;
   assign bus.abort   = abort_h | abort_c;
   assign bus.halt    = halt_c;
   assign bus.icycle  = icycle_c;
   assign bus.pc      = pc_c;
   assign bus.bp_addr = bpa_h;
   assign bus.bp_en   = bpe_h;

   cyc_t vec [NV];
   int   vj;
   exp_t exp_q [$];
   int   checks = 0;
   int   fails  = 0;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
      end
   endtask

   // Reference: walk the run's enabled cycles and apply the stop rules directly.
   function automatic exp_t model_run(input logic [1:0] m, input int unsigned len, input int nsteps);
      exp_t e;
      cyc_t v;
      int   j;
      bit   fin;
      bit   hit;
      e.cause = 3'd0; e.cyc = 0; e.ins = 0;
      j = 0; fin = 1'b0;
      if (m == 2'b01) begin
         for (int s = 0; s < nsteps && !fin; s++) begin
            for (int pos = 0; !fin; pos++) begin
               v = vec[j]; j++; e.cyc = j; e.ins += int'(v.icycle);
               if (v.abort)                          begin e.cause = 3'd1; fin = 1'b1; end
               else if (v.halt)                      begin e.cause = 3'd2; fin = 1'b1; end
               else if (MAXC != 0 && e.cyc == MAXC)  begin e.cause = 3'd5; fin = 1'b1; end
               else if (pos > 0 && v.icycle)         break;
            end
         end
         if (!fin) e.cause = 3'd1;
      end else if (m[1] && len == 0) begin
         e.cause = 3'd4;
      end else begin
         for (int k = 0; k < NV && !fin; k++) begin
            v = vec[k]; e.cyc = k + 1; e.ins += int'(v.icycle);
            hit = 1'b0;
            for (int i = 0; i < int'(NUM_BP); i++)
               if (bpe_h[i] && v.pc == bpa_h[i*ADDR_W +: ADDR_W]) hit = 1'b1;
            fin = 1'b1;
            if (v.abort)                                        e.cause = 3'd1;
            else if (v.halt)                                    e.cause = 3'd2;
            else if (v.icycle && hit)                           e.cause = 3'd3;
            else if (m == 2'b10 && e.cyc == int'(len))          e.cause = 3'd4;
            else if (m == 2'b11 && v.icycle && e.ins == int'(len)) e.cause = 3'd4;
            else if (MAXC != 0 && e.cyc == MAXC)                e.cause = 3'd5;
            else                                                fin = 1'b0;
         end
      end
      return e;
   endfunction

   // Core model: present the next table entry during each enabled cycle
   initial begin
      abort_c = 1'b0; halt_c = 1'b0; icycle_c = 1'b0; pc_c = '0; vj = 0;
      forever begin
         @(posedge clk); #1;
         if (bus.cpu_en) begin
            cyc_t v;
            v = vec[(vj < NV) ? vj : NV-1];
            abort_c = v.abort; halt_c = v.halt; icycle_c = v.icycle; pc_c = v.pc;
            vj++;
         end else begin
            abort_c = 1'b0; halt_c = 1'b0; icycle_c = 1'b0;
         end
      end
   end

   // Monitor: on each done pulse pop the expected result and compare
   initial begin
      int  en_seen;
      bit  post;
      exp_t e;
      en_seen = 0; post = 1'b0;
      forever begin
         @(negedge clk);
         if (post) begin
            post = 1'b0;
            chk("done_one_cycle", longint'(bus.done), 0);
            chk("idle_after_done", longint'(bus.busy), 0);
         end
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("stop_cause", longint'(bus.stop_cause), longint'(e.cause));
               chk("cycle_cnt", longint'(bus.cycle_cnt), longint'(e.cyc));
               chk("instr_cnt", longint'(bus.instr_cnt), longint'(e.ins));
               chk("cpu_en_cycles", longint'(en_seen), longint'(e.cyc));
               chk("busy_in_done", longint'(bus.busy), 1);
               chk("cpu_en_in_done", longint'(bus.cpu_en), 0);
            end
            post = 1'b1;
         end
         if (!bus.busy) en_seen = 0;
         else if (bus.cpu_en) en_seen++;
      end
   end

   task automatic clear_vec();
      for (int k = 0; k < NV; k++) vec[k] = '0;
   endtask

   task automatic run(input logic [1:0] m, input int unsigned len, input int nsteps, input bit dbl);
      int n;
      exp_q.push_back(model_run(m, len, nsteps));
      @(posedge clk); #1;
      vj = 0; mode_h = m; len_h = CNT_W'(len); start_h = 1'b1;
      @(posedge clk); #1;
      if (dbl) begin
         mode_h = ~m;
         @(posedge clk); #1;
      end
      start_h = 1'b0;
      if (m == 2'b01) begin
         for (int s = 0; s < nsteps; s++) begin
            if (!bus.busy || bus.done) break;
            step_h = 1'b1;
            @(posedge clk); #1;
            step_h = 1'b0;
            n = 0;
            while (bus.cpu_en && n < 60) begin @(posedge clk); #1; n++; end
         end
         if (bus.busy && !bus.done) begin
            abort_h = 1'b1;
            @(posedge clk); #1;
            abort_h = 1'b0;
         end
      end
      n = 0;
      while (bus.busy && n < 100) begin @(posedge clk); #1; n++; end
      if (bus.busy) chk("run_finished", 1, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [1:0] m;
      reset = 1'b0;
      start_h = 1'b0; step_h = 1'b0; abort_h = 1'b0; mode_h = 2'b00; len_h = '0;
      bpa_h = '0; bpe_h = '0;
      clear_vec();
      #2;
      chk("rst_cpu_en", longint'(bus.cpu_en), 0);
      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_done", longint'(bus.done), 0);
      chk("rst_cause", longint'(bus.stop_cause), 0);
      chk("rst_cycle_cnt", longint'(bus.cycle_cnt), 0);
      chk("rst_instr_cnt", longint'(bus.instr_cnt), 0);
      #10 reset = 1'b1;

      // free run into the watchdog
      run(2'b00, 0, 0, 1'b0);
      // N cycles, and N=0
      run(2'b10, 4, 0, 1'b0);
      run(2'b10, 0, 0, 1'b0);
      // N instructions, icycle every 2nd enabled cycle
      for (int k = 0; k < NV; k++) vec[k].icycle = (k % 2 == 1);
      run(2'b11, 3, 0, 1'b0);
      // breakpoint on slot 1 at 5th enabled cycle, then halt in the same cycle
      clear_vec();
      bpe_h = 2'b10; bpa_h = {16'h0008, 16'h0000};
      vec[4].pc = 16'h0008; vec[4].icycle = 1'b1;
      run(2'b00, 0, 0, 1'b0);
      vec[4].halt = 1'b1;
      run(2'b00, 0, 0, 1'b0);
      // step mode, icycle every 3rd cycle, two steps then abort
      clear_vec(); bpe_h = '0;
      for (int k = 0; k < NV; k++) vec[k].icycle = (k % 3 == 2);
      run(2'b01, 0, 2, 1'b0);

      // asynchronous reset in the middle of a free run
      clear_vec();
      @(posedge clk); #1;
      vj = 0; mode_h = 2'b00; start_h = 1'b1;
      @(posedge clk); #1; start_h = 1'b0;
      repeat (4) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("mid_rst_cpu_en", longint'(bus.cpu_en), 0);
      chk("mid_rst_busy", longint'(bus.busy), 0);
      chk("mid_rst_cycle_cnt", longint'(bus.cycle_cnt), 0);
      chk("mid_rst_instr_cnt", longint'(bus.instr_cnt), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      run(2'b10, 3, 0, 1'b0);

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         m = 2'($urandom_range(0, 3));
         bpa_h = {16'($urandom_range(0, 15)), 16'($urandom_range(0, 15))};
         bpe_h = 2'($urandom_range(0, 3));
         for (int k = 0; k < NV; k++) begin
            vec[k].abort  = (m != 2'b01) && ($urandom_range(0, 29) == 0);
            vec[k].halt   = ($urandom_range(0, 19) == 0);
            vec[k].icycle = 1'($urandom_range(0, 1));
            vec[k].pc     = 16'($urandom_range(0, 15));
         end
         run(m, $urandom_range(0, 12), $urandom_range(1, 3),
             (m != 2'b01) && ($urandom_range(0, 1) == 1));
      end

      if (exp_q.size() != 0) chk("scoreboard_drained", longint'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run controller that sits between the testbench/host and the `computer` core and gates the core's progress through a clock-enable. It supports free run, single-instruction step, run-N-cycles and run-N-instructions, with up to NUM_BP PC breakpoints and a cycle watchdog. It reports why the run stopped, plus cycle and instruction counts, so benches and future debug hardware no longer rely on a fixed simulation-time cutoff.

## Interface
- CNT_W, 32: width of cycle/instruction counters and run_len
- ADDR_W, 16: PC width
- NUM_BP, 2: number of breakpoint comparators (≥1)
- MAX_CYCLES, 10: watchdog limit in enabled cycles; 0 disables the watchdog
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  pulse; begins a run when idle
- mode  input  2  00 free run, 01 step, 10 N cycles, 11 N instructions; sampled with start
- run_len  input  CNT_W  N for modes 10/11; sampled with start
- step  input  1  pulse; executes one instruction in step mode
- abort  input  1  level; ends any active run
- halt  input  1  core halted
- icycle  input  1  core is at an instruction boundary (fetch cycle)
- pc  input  ADDR_W  core program counter
- bp_addr  input  NUM_BP*ADDR_W  breakpoint addresses; slot i at [i*ADDR_W +: ADDR_W]
- bp_en  input  NUM_BP  per-slot enable
- cpu_en  output  1  registered clock-enable to the core
- busy  output  1  run in progress (any state but IDLE)
- done  output  1  one-cycle pulse when a run ends
- stop_cause  output  3  0 none, 1 abort, 2 halt, 3 breakpoint, 4 count, 5 timeout
- cycle_cnt  output  CNT_W  enabled cycles in current/last run
- instr_cnt  output  CNT_W  enabled cycles with icycle=1 in current/last run

## Operation
- States: IDLE, RUN, STEP_WAIT, STEP_EXEC, DONE.
- IDLE: start=1 clears both counters and stop_cause, latches mode/run_len. Mode 01 → STEP_WAIT; modes 10/11 with run_len=0 → DONE with cause 4; otherwise → RUN. start outside IDLE is ignored.
- RUN: cpu_en=1. Each cycle, stop conditions are evaluated on the inputs of that cycle; on a hit → DONE.
- STEP_WAIT: cpu_en=0. step=1 → STEP_EXEC; abort=1 → DONE, cause 1.
- STEP_EXEC: cpu_en=1 until a cycle with icycle=1 after the first enabled cycle, then → STEP_WAIT. Stop conditions except breakpoint/count apply.
- DONE: done=1, cpu_en=0, → IDLE next cycle. Counters and stop_cause hold until the next start.
- Stop conditions, evaluated only in cycles where cpu_en=1 (abort in any busy state), in priority order:
  - abort=1 → 1
  - halt=1 → 2
  - breakpoint: icycle=1, bp_en[i]=1 and pc==bp_addr[i] for any i, modes 00/10/11 → 3
  - count: mode 10 and cycle_cnt+1==run_len, or mode 11, icycle=1 and instr_cnt+1==run_len → 4
  - timeout: MAX_CYCLES≠0 and cycle_cnt+1==MAX_CYCLES → 5
- Counters increment on every enabled cycle, including the stopping cycle, and saturate at all-ones (no wrap).

## Timing
- Reset (asynchronous, reset=0): state IDLE, cpu_en=0, busy=0, done=0, stop_cause=0, both counters 0. This holds mid-run; cpu_en drops without waiting for a clock edge.
- start sampled at edge k: busy=1 and cpu_en=1 (non-step modes) from edge k+1.
- Stop detected in the enabled cycle ending at edge m: at edge m+1 cpu_en=0, done=1, stop_cause valid. At edge m+2 done=0 and busy=0.
- Mode 10 with run_len=N: exactly N enabled cycles, cycle_cnt=N at done.
- Simultaneous events resolve by the priority above; only one cause is recorded.
- step pulses in STEP_EXEC or RUN are ignored.

## Test plan
- Free run, MAX_CYCLES=10, no halt/bp → cpu_en high 10 cycles, done pulse, stop_cause=5, cycle_cnt=10.
- Mode 10, run_len=4 → cpu_en high exactly 4 cycles, stop_cause=4, cycle_cnt=4. Repeat with run_len=0 → done one cycle after start, cpu_en never high, cycle_cnt=0.
- Mode 11, run_len=3, icycle every 2nd enabled cycle → stop_cause=4, instr_cnt=3, cycle_cnt=6.
- Free run, bp_en=2'b10, bp_addr slot1=16'h0008, pc=8 with icycle=1 on the 5th enabled cycle → stop_cause=3, cycle_cnt=5. Same cycle with halt=1 → stop_cause=2.
- Step mode, icycle every 3rd cycle: two step pulses → two bursts of cpu_en, instr_cnt=2. Then abort → done, stop_cause=1.
- reset=0 asynchronously in mid-RUN → cpu_en, busy and counters 0 immediately. After release, start works normally.
